// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP-1 controller.
//   - NUM_T and the one-hot T-state type / constants (T_HALT is the all-zero state)
//   - opcode constants
//   - ctrl_word_t: packed control word driven to the datapath
//   - is_nop(): opcodes with an empty execute phase
package sap_pkg;

    localparam int unsigned NUM_T = 6;

    typedef logic [NUM_T-1:0] tstate_t;

    localparam tstate_t T1     = 6'b000001;
    localparam tstate_t T2     = 6'b000010;
    localparam tstate_t T3     = 6'b000100;
    localparam tstate_t T4     = 6'b001000;
    localparam tstate_t T5     = 6'b010000;
    localparam tstate_t T6     = 6'b100000;
    localparam tstate_t T_HALT = 6'b000000;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic mar_load;
        logic mem_out;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_sub;
        logic alu_out;
        logic out_load;
    } ctrl_word_t;

    function automatic logic is_nop(input logic [3:0] op);
        return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    endfunction

endpackage

// File: rtl/sap_controller_if.sv
// sap_controller_if: opcode input and control/status outputs of the SAP-1 controller.
//   master modport: controller side (drives controls, reads opcode)
//   slave modport : datapath side (drives opcode, reads controls)
interface sap_controller_if;
    import sap_pkg::*;

    logic [3:0] opcode;
    logic       pc_inc;
    logic       pc_out;
    logic       mar_load;
    logic       mem_out;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_sub;
    logic       alu_out;
    logic       out_load;
    logic       halted;
    tstate_t    t_state;

    modport master (
        input  opcode,
        output pc_inc, pc_out, mar_load, mem_out, ir_load, ir_out,
        output a_load, a_out, b_load, alu_sub, alu_out, out_load,
        output halted, t_state
    );

    modport slave (
        output opcode,
        input  pc_inc, pc_out, mar_load, mem_out, ir_load, ir_out,
        input  a_load, a_out, b_load, alu_sub, alu_out, out_load,
        input  halted, t_state
    );

endinterface

// File: rtl/ring_counter.sv
// ring_counter: one-hot T1..T6 state counter.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset, forces T1
//   clear     - return to T1 on the next edge (early instruction end)
//   hold      - enter/stay in the all-zero HALT state
//   t_state_o - current one-hot state
// Any non-one-hot encoding outside of hold recovers to T1 on the next edge.
module ring_counter
    import sap_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  logic    hold,
    output tstate_t t_state_o
);

    tstate_t state_q, state_d;
    logic    onehot;

    assign onehot = (state_q != '0) && ((state_q & (state_q - tstate_t'(1))) == '0);

    always_comb begin
        state_d = {state_q[NUM_T-2:0], state_q[NUM_T-1]};
        if (hold) begin
            state_d = T_HALT;
        end else if (clear || !onehot) begin
            state_d = T1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state_o = state_q;

endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 controller-sequencer.
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset; masks all controls while high
//   ctl_if - sap_controller_if.master: opcode in; control word, halted, t_state out
// Control outputs are combinational from (T-state, opcode). HLT in T4 enters
// HALT on the closing edge; only rst leaves it.
// Optional macro SAP_EARLY_END_EN: instructions return to T1 after their last
// non-empty T-state (LDA after T5, OUT after T4, NOP after T3).
module sap_controller #(
    parameter int unsigned NUM_T = 6
) (
    input  logic               clk,
    input  logic               rst,
    sap_controller_if.master   ctl_if
);
    import sap_pkg::*;

    if (NUM_T != sap_pkg::NUM_T) begin : g_num_t_check
        $error("sap_controller: NUM_T must be 6");
    end

    tstate_t    t_state;
    ctrl_word_t cw;
    logic       halted_q, halted_d;
    logic       hlt_t4;
    logic       clear;
    logic       hold;

    ring_counter u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hold      (hold),
        .t_state_o (t_state)
    );

    assign hlt_t4   = (t_state == T4) && (ctl_if.opcode == OP_HLT) && !halted_q;
    assign hold     = halted_q || hlt_t4;
    assign halted_d = halted_q || hlt_t4;

`ifdef SAP_EARLY_END_EN
    // NOP is decided in T3 because its T4 would be empty.
    assign clear = ((t_state == T3) && is_nop(ctl_if.opcode))
                || ((t_state == T4) && (ctl_if.opcode == OP_OUT))
                || ((t_state == T5) && (ctl_if.opcode == OP_LDA));
`else
    assign clear = 1'b0;
`endif

    always_comb begin
        cw = '0;
        unique case (t_state)
            T1: begin
                cw.pc_out   = 1'b1;
                cw.mar_load = 1'b1;
            end
            T2: cw.pc_inc = 1'b1;
            T3: begin
                cw.mem_out = 1'b1;
                cw.ir_load = 1'b1;
            end
            T4: begin
                case (ctl_if.opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw.ir_out   = 1'b1;
                        cw.mar_load = 1'b1;
                    end
                    OP_OUT: begin
                        cw.a_out    = 1'b1;
                        cw.out_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (ctl_if.opcode)
                    OP_LDA: begin
                        cw.mem_out = 1'b1;
                        cw.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.mem_out = 1'b1;
                        cw.b_load  = 1'b1;
                        cw.alu_sub = (ctl_if.opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (ctl_if.opcode inside {OP_ADD, OP_SUB}) begin
                    cw.alu_out = 1'b1;
                    cw.a_load  = 1'b1;
                    cw.alu_sub = (ctl_if.opcode == OP_SUB);
                end
            end
            default: ;
        endcase
        if (rst || halted_q) begin
            cw = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign ctl_if.pc_inc   = cw.pc_inc;
    assign ctl_if.pc_out   = cw.pc_out;
    assign ctl_if.mar_load = cw.mar_load;
    assign ctl_if.mem_out  = cw.mem_out;
    assign ctl_if.ir_load  = cw.ir_load;
    assign ctl_if.ir_out   = cw.ir_out;
    assign ctl_if.a_load   = cw.a_load;
    assign ctl_if.a_out    = cw.a_out;
    assign ctl_if.b_load   = cw.b_load;
    assign ctl_if.alu_sub  = cw.alu_sub;
    assign ctl_if.alu_out  = cw.alu_out;
    assign ctl_if.out_load = cw.out_load;
    assign ctl_if.halted   = halted_q;
    assign ctl_if.t_state  = t_state;

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed self-checking bench for sap_controller.
// Control word bit order: pc_inc pc_out mar_load mem_out ir_load ir_out
//                         a_load a_out b_load alu_sub alu_out out_load
module tb_sap_controller;

    localparam logic [11:0] C_PC_INC   = 12'b1000_0000_0000;
    localparam logic [11:0] C_PC_OUT   = 12'b0100_0000_0000;
    localparam logic [11:0] C_MAR_LOAD = 12'b0010_0000_0000;
    localparam logic [11:0] C_MEM_OUT  = 12'b0001_0000_0000;
    localparam logic [11:0] C_IR_LOAD  = 12'b0000_1000_0000;
    localparam logic [11:0] C_IR_OUT   = 12'b0000_0100_0000;
    localparam logic [11:0] C_A_LOAD   = 12'b0000_0010_0000;
    localparam logic [11:0] C_A_OUT    = 12'b0000_0001_0000;
    localparam logic [11:0] C_B_LOAD   = 12'b0000_0000_1000;
    localparam logic [11:0] C_ALU_SUB  = 12'b0000_0000_0100;
    localparam logic [11:0] C_ALU_OUT  = 12'b0000_0000_0010;
    localparam logic [11:0] C_OUT_LOAD = 12'b0000_0000_0001;
    localparam logic [11:0] C_NONE     = 12'b0;

    localparam logic [11:0] F1 = C_PC_OUT | C_MAR_LOAD;
    localparam logic [11:0] F2 = C_PC_INC;
    localparam logic [11:0] F3 = C_MEM_OUT | C_IR_LOAD;
    localparam logic [11:0] E_IRM = C_IR_OUT | C_MAR_LOAD;

`ifdef SAP_EARLY_END_EN
    localparam int LEN_LDA = 5;
    localparam int LEN_OUT = 4;
    localparam int LEN_NOP = 3;
`else
    localparam int LEN_LDA = 6;
    localparam int LEN_OUT = 6;
    localparam int LEN_NOP = 6;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    sap_controller_if u_if ();

    sap_controller #(
        .NUM_T (6)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .ctl_if (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] obs_cw();
        return {u_if.pc_inc, u_if.pc_out, u_if.mar_load, u_if.mem_out, u_if.ir_load,
                u_if.ir_out, u_if.a_load, u_if.a_out, u_if.b_load, u_if.alu_sub,
                u_if.alu_out, u_if.out_load};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] ecw, input logic [5:0] et,
                       input logic eh);
        checks++;
        assert (obs_cw() === ecw) else begin
            errors++;
            $error("FAIL %s ctrl got=%b exp=%b", tag, obs_cw(), ecw);
        end
        checks++;
        assert (u_if.t_state === et) else begin
            errors++;
            $error("FAIL %s t_state got=%b exp=%b", tag, u_if.t_state, et);
        end
        checks++;
        assert (u_if.halted === eh) else begin
            errors++;
            $error("FAIL %s halted got=%b exp=%b", tag, u_if.halted, eh);
        end
    endtask

    // Runs one instruction starting at T1; junk opcodes during T1/T2 must not matter.
    task automatic instr(input logic [3:0] op, input logic [11:0] e4, input logic [11:0] e5,
                         input logic [11:0] e6, input int len, input string tag);
        u_if.opcode = ~op;
        #1 chk({tag, "/T1"}, F1, 6'b000001, 1'b0);
        tick();
        u_if.opcode = op ^ 4'h5;
        #1 chk({tag, "/T2"}, F2, 6'b000010, 1'b0);
        tick();
        u_if.opcode = op;
        #1 chk({tag, "/T3"}, F3, 6'b000100, 1'b0);
        tick();
        if (len >= 4) begin
            chk({tag, "/T4"}, e4, 6'b001000, 1'b0);
            tick();
        end
        if (len >= 5) begin
            chk({tag, "/T5"}, e5, 6'b010000, 1'b0);
            tick();
        end
        if (len >= 6) begin
            chk({tag, "/T6"}, e6, 6'b100000, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [5:0]  et;
        logic [11:0] ef;
        int          phase;
        int          drv;

        rst = 1'b1;
        u_if.opcode = 4'h0;
        #1 chk("reset_async", C_NONE, 6'b000001, 1'b0);
        repeat (2) tick();
        chk("reset", C_NONE, 6'b000001, 1'b0);
        rst = 1'b0;

        instr(4'h0, E_IRM, C_MEM_OUT | C_A_LOAD, C_NONE, LEN_LDA, "lda");
        instr(4'h2, E_IRM, C_MEM_OUT | C_B_LOAD | C_ALU_SUB, C_ALU_OUT | C_A_LOAD | C_ALU_SUB,
              6, "sub");
        instr(4'h1, E_IRM, C_MEM_OUT | C_B_LOAD, C_ALU_OUT | C_A_LOAD, 6, "add");
        instr(4'hE, C_A_OUT | C_OUT_LOAD, C_NONE, C_NONE, LEN_OUT, "out");
        instr(4'h7, C_NONE, C_NONE, C_NONE, LEN_NOP, "nop");
        instr(4'h0, E_IRM, C_MEM_OUT | C_A_LOAD, C_NONE, LEN_LDA, "lda2");

        // HLT: T4 is empty, then HALT for good.
        instr(4'hF, C_NONE, C_NONE, C_NONE, 4, "hlt");
        for (int i = 0; i < 20; i++) begin
            u_if.opcode = 4'($urandom_range(0, 15));
            #1 chk("halted", C_NONE, 6'b000000, 1'b1);
            tick();
        end
        rst = 1'b1;
        #1 chk("halt_rst", C_NONE, 6'b000001, 1'b0);
        tick();
        rst = 1'b0;

        // Reset asserted during T5 of ADD.
        instr(4'h1, E_IRM, C_NONE, C_NONE, 4, "mid");
        #1 chk("mid/T5", C_MEM_OUT | C_B_LOAD, 6'b010000, 1'b0);
        #1 rst = 1'b1;
        #1 chk("mid/rst", C_NONE, 6'b000001, 1'b0);
        tick();
        chk("mid/rst_edge", C_NONE, 6'b000001, 1'b0);
        rst = 1'b0;

        // Random opcodes (no HLT) against a small phase model.
        phase = 1;
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 14));
            u_if.opcode = op;
            #1;
            drv = int'(u_if.pc_out) + int'(u_if.mem_out) + int'(u_if.ir_out)
                + int'(u_if.a_out) + int'(u_if.alu_out);
            checks++;
            assert (drv <= 1) else begin
                errors++;
                $error("FAIL bus_drivers got=%0d exp<=1", drv);
            end
            et = 6'b000001 << (phase - 1);
            checks++;
            assert (u_if.t_state === et) else begin
                errors++;
                $error("FAIL rand_t_state got=%b exp=%b", u_if.t_state, et);
            end
            if (phase <= 3) begin
                ef = (phase == 1) ? F1 : (phase == 2) ? F2 : F3;
                checks++;
                assert (obs_cw() === ef) else begin
                    errors++;
                    $error("FAIL rand_fetch op=%h got=%b exp=%b", op, obs_cw(), ef);
                end
            end
`ifdef SAP_EARLY_END_EN
            if ((phase == 3 && !(op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF}))
                || (phase == 4 && op == 4'hE) || (phase == 5 && op == 4'h0)) begin
                phase = 1;
            end else begin
                phase = (phase % 6) + 1;
            end
`else
            phase = (phase % 6) + 1;
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
